// File: rtl/tip_hello_reset_seq_pkg.sv
// Shared state encoding and default configuration for the tip_hello reset sequencer.
package tip_hello_reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_SW_HOLD   = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_SYNC_STAGES        = 2;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 256;
  localparam int unsigned DEF_STAGE_GAP_CYCLES   = 16;
  localparam int unsigned DEF_NUM_DOMAINS        = 3;
  localparam int unsigned LOSS_COUNT_W           = 8;

endpackage

// File: rtl/tip_hello_sync_ff.sv
// Multi-stage flip-flop synchronizer with asynchronous active-low clear.
module tip_hello_sync_ff
  import tip_hello_reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rstnn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/tip_hello_reset_sequencer.sv
// Staged reset release gated on a stable PLL lock, with software reset and lock-loss recovery.
// Optional loss_count output enabled by TIP_HELLO_RESET_SEQ_LOSS_COUNT_EN.
module tip_hello_reset_sequencer
  import tip_hello_reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned STAGE_GAP_CYCLES   = DEF_STAGE_GAP_CYCLES,
  parameter int unsigned NUM_DOMAINS        = DEF_NUM_DOMAINS
) (
  input  logic                   clk,
  input  logic                   rstnn,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] domain_rstnn,
  output logic                   all_released
`ifdef TIP_HELLO_RESET_SEQ_LOSS_COUNT_EN
  ,
  output logic [LOSS_COUNT_W-1:0] loss_count
`endif
);

  localparam int unsigned STABLE_W = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int unsigned GAP_W    = $clog2(STAGE_GAP_CYCLES) + 1;
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(STAGE_GAP_CYCLES - 1);

  logic                   lock_s;
  seq_state_e             state_q, state_d;
  logic [STABLE_W-1:0]    stable_cnt_q, stable_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [NUM_DOMAINS-1:0] domain_d;
  logic                   all_d;
  logic                   start_release;
  logic                   lock_lost;

  tip_hello_sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk),
    .rstnn(rstnn),
    .d    (pll_locked),
    .q    (lock_s)
  );

  // Next-state and next-output logic; lock loss overrides everything else.
  always_comb begin
    state_d       = state_q;
    stable_cnt_d  = stable_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    domain_d      = domain_rstnn;
    all_d         = all_released;
    start_release = 1'b0;
    lock_lost     = (state_q != ST_WAIT_LOCK) && !lock_s;

    case (state_q)
      ST_WAIT_LOCK: begin
        domain_d = '0;
        all_d    = 1'b0;
        if (lock_s) begin
          state_d      = ST_STABLE;
          stable_cnt_d = '0;
        end
      end
      ST_STABLE: begin
        if (stable_cnt_q == STABLE_LAST) begin
          start_release = 1'b1;
        end else begin
          stable_cnt_d = stable_cnt_q + STABLE_W'(1);
        end
      end
      ST_RELEASE: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          // Domains release as a thermometer code, bit 0 first.
          domain_d  = NUM_DOMAINS'({domain_rstnn, 1'b1});
          if (domain_d[NUM_DOMAINS-1]) begin
            state_d = ST_RUN;
            all_d   = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_RUN: begin
        if (sw_reset_req) begin
          state_d   = ST_SW_HOLD;
          domain_d  = '0;
          all_d     = 1'b0;
          gap_cnt_d = '0;
        end
      end
      ST_SW_HOLD: begin
        if (gap_cnt_q == GAP_LAST) begin
          start_release = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d  = ST_WAIT_LOCK;
        domain_d = '0;
        all_d    = 1'b0;
      end
    endcase

    if (start_release) begin
      domain_d     = NUM_DOMAINS'(1);
      gap_cnt_d    = '0;
      stable_cnt_d = '0;
      if (NUM_DOMAINS == 1) begin
        state_d = ST_RUN;
        all_d   = 1'b1;
      end else begin
        state_d = ST_RELEASE;
      end
    end

    if (lock_lost) begin
      state_d      = ST_WAIT_LOCK;
      domain_d     = '0;
      all_d        = 1'b0;
      stable_cnt_d = '0;
      gap_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q      <= ST_WAIT_LOCK;
      stable_cnt_q <= '0;
      gap_cnt_q    <= '0;
      domain_rstnn <= '0;
      all_released <= 1'b0;
    end else begin
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      domain_rstnn <= domain_d;
      all_released <= all_d;
    end
  end

`ifdef TIP_HELLO_RESET_SEQ_LOSS_COUNT_EN
  // Saturating count of lock-loss events, cleared only by rstnn.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      loss_count <= '0;
    end else if (lock_lost && (loss_count != '1)) begin
      loss_count <= loss_count + LOSS_COUNT_W'(1);
    end
  end
`endif

endmodule
